// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer
// ---------------------------------------------------------------------------
// Multi-channel LED PWM dimmer driven by three push-buttons.
//   - key_up / key_dn : raise / lower the shadow duty of the selected channel
//                       (debounced, with auto-repeat while held)
//   - key_sel         : advance the selected channel (debounced, no repeat)
// Shadow duties are copied into the active duty registers only at PWM period
// boundaries. This prevents glitches on the LED outputs.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   breathe   (only with LED_PWM_BREATHE_EN) triangle-ramp the selected channel
//   key_up    raw button, high = pressed
//   key_dn    raw button, high = pressed
//   key_sel   raw button, high = pressed
//   led       registered PWM outputs, high = LED on
//   sel_ch    currently selected channel index
//   duty_sel  committed (active) duty of the selected channel
//
// Optional feature macro: LED_PWM_BREATHE_EN
// ---------------------------------------------------------------------------
module led_pwm_dimmer #(
  parameter int N_CH          = 4,
  parameter int PWM_W         = 10,
  parameter int CLK_DIV       = 16,
  parameter int STEP          = 1,
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_CYCLES = 2000000
) (
  input  logic                                       clk,
  input  logic                                       rst,
`ifdef LED_PWM_BREATHE_EN
  input  logic                                       breathe,
`endif
  input  logic                                       key_up,
  input  logic                                       key_dn,
  input  logic                                       key_sel,
  output logic [N_CH-1:0]                            led,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] sel_ch,
  output logic [PWM_W-1:0]                           duty_sel
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [PWM_W:0]   STEP_X   = (PWM_W+1)'(STEP);

  // -------------------------------------------------------------------------
  // Key path: 2-FF synchroniser, debouncer and press/repeat event pulse.
  // Index 0 = up, 1 = dn, 2 = sel.
  // -------------------------------------------------------------------------
  logic [2:0] key_raw;
  logic [2:0] key_evt;
  assign key_raw = {key_sel, key_dn, key_up};

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    localparam bit HAS_REPEAT = (gi != 2);
    logic             sync1_q, sync2_q, stable_q, evt_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [REP_W-1:0] rep_cnt_q;
    logic             accept, rise, rep_fire;

    // Accept the new level on the DEB_CYCLES-th consecutive differing clk.
    assign accept   = (sync2_q != stable_q) && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
    assign rise     = accept & sync2_q;
    assign rep_fire = HAS_REPEAT && stable_q && (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        stable_q  <= 1'b0;
        deb_cnt_q <= '0;
        rep_cnt_q <= '0;
        evt_q     <= 1'b0;
      end else begin
        sync1_q <= key_raw[gi];
        sync2_q <= sync1_q;
        // Any return to the stable level (bounce) restarts the count.
        if (sync2_q == stable_q) begin
          deb_cnt_q <= '0;
        end else if (accept) begin
          stable_q  <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
        // Repeat timer restarts on the press and after every repeat event.
        if (rise || !stable_q || rep_fire) rep_cnt_q <= '0;
        else                               rep_cnt_q <= rep_cnt_q + 1'b1;
        evt_q <= rise | rep_fire;
      end
    end

    assign key_evt[gi] = evt_q;
  end

  // Opposing up/dn events in the same clk cancel.
  logic adj_up, adj_dn, sel_evt;
  assign adj_up  = key_evt[0] & ~key_evt[1];
  assign adj_dn  = key_evt[1] & ~key_evt[0];
  assign sel_evt = key_evt[2];

  // -------------------------------------------------------------------------
  // Prescaler, PWM counter and channel select
  // -------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             tick, boundary;

  assign tick     = (pre_q == PRE_W'(CLK_DIV - 1));
  assign boundary = tick && (pwm_cnt_q == DUTY_MAX);

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    sel_d     = sel_q;
    if (sel_evt) sel_d = (sel_q == SEL_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      pwm_cnt_q <= '0;
      sel_q     <= '0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      sel_q     <= sel_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel shadow / active duty and PWM output
  // -------------------------------------------------------------------------
  logic [PWM_W-1:0] duty_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [PWM_W-1:0] shadow_q, shadow_d, duty_q, inc_val, dec_val;
    logic [PWM_W:0]   sum;
    logic             led_q, is_sel;

    assign is_sel  = (sel_q == SEL_W'(gi));
    // Saturating arithmetic at PWM_W+1 bits.
    assign sum     = {1'b0, shadow_q} + STEP_X;
    assign inc_val = (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[PWM_W-1:0];
    assign dec_val = ({1'b0, shadow_q} < STEP_X) ? '0 : shadow_q - STEP_X[PWM_W-1:0];

`ifdef LED_PWM_BREATHE_EN
    logic dir_up_q, dir_up_d;

    // While breathing, the selected channel ramps one step per period and
    // ignores the up/dn keys. Deselecting or dropping breathe freezes it.
    always_comb begin
      shadow_d = shadow_q;
      dir_up_d = dir_up_q;
      if (is_sel && breathe) begin
        if (boundary) begin
          if (dir_up_q) begin
            if (shadow_q == DUTY_MAX) begin
              dir_up_d = 1'b0;
              shadow_d = dec_val;
            end else begin
              shadow_d = inc_val;
            end
          end else begin
            if (shadow_q == '0) begin
              dir_up_d = 1'b1;
              shadow_d = inc_val;
            end else begin
              shadow_d = dec_val;
            end
          end
        end
      end else if (is_sel && adj_up) begin
        shadow_d = inc_val;
      end else if (is_sel && adj_dn) begin
        shadow_d = dec_val;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) dir_up_q <= 1'b1;
      else     dir_up_q <= dir_up_d;
    end
`else
    always_comb begin
      shadow_d = shadow_q;
      if (is_sel && adj_up)      shadow_d = inc_val;
      else if (is_sel && adj_dn) shadow_d = dec_val;
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
        duty_q   <= '0;
        led_q    <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        if (boundary) duty_q <= shadow_q;
        // Full-scale duty means no off tick at all.
        led_q <= (pwm_cnt_q < duty_q) || (duty_q == DUTY_MAX);
      end
    end

    assign led[gi]      = led_q;
    assign duty_arr[gi] = duty_q;
  end

  assign sel_ch   = sel_q;
  assign duty_sel = duty_arr[sel_q];

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Testbench for led_pwm_dimmer: randomised key presses with bounce, checked
// against a behavioural model of channel duties and selection. LED outputs are
// checked by counting high samples over a 16-clk window.
module tb_led_pwm_dimmer;

  localparam int N_CH  = 2;
  localparam int PWM_W = 4;
  localparam int CDIV  = 1;
  localparam int STEP  = 1;
  localparam int DEB   = 4;
  localparam int REP   = 40;
  localparam int MAXV  = (1 << PWM_W) - 1;
  localparam int PER   = 1 << PWM_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_up = 1'b0, key_dn = 1'b0, key_sel = 1'b0;
`ifdef LED_PWM_BREATHE_EN
  logic breathe = 1'b0;
`endif
  logic [N_CH-1:0]  led;
  logic [0:0]       sel_ch;
  logic [PWM_W-1:0] duty_sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: per-channel target duty and selected channel.
  int shadow_m [N_CH];
  int sel_m;

  led_pwm_dimmer #(
    .N_CH(N_CH), .PWM_W(PWM_W), .CLK_DIV(CDIV), .STEP(STEP),
    .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef LED_PWM_BREATHE_EN
    .breathe(breathe),
`endif
    .key_up(key_up),
    .key_dn(key_dn),
    .key_sel(key_sel),
    .led(led),
    .sel_ch(sel_ch),
    .duty_sel(duty_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit u, input bit d, input bit s);
    key_up  = u;
    key_dn  = d;
    key_sel = s;
  endtask

  function automatic int sat_up(input int v);
    return (v + STEP > MAXV) ? MAXV : v + STEP;
  endfunction

  function automatic int sat_dn(input int v);
    return (v - STEP < 0) ? 0 : v - STEP;
  endfunction

  function automatic int led_highs(input int d);
    return (d == MAXV) ? PER : d;
  endfunction

  task automatic model_reset();
    sel_m = 0;
    for (int c = 0; c < N_CH; c++) shadow_m[c] = 0;
  endtask

  // Bounce (runs shorter than the debounce time), hold, release. Holds are
  // kept either short (<REP) or 40k+20 clks so repeat counts are unambiguous.
  task automatic press(input bit up, input bit dn, input bit sel,
                       input int hold, input int nbounce);
    int nev;
    for (int b = 0; b < nbounce; b++) begin
      drive(up, dn, sel);
      tick($urandom_range(1, DEB - 1));
      drive(1'b0, 1'b0, 1'b0);
      tick($urandom_range(1, DEB - 1));
    end
    drive(up, dn, sel);
    tick(hold);
    drive(1'b0, 1'b0, 1'b0);
    tick(DEB + 8);
    nev = (up || dn) ? 1 + hold / REP : 1;
    for (int e = 0; e < nev; e++) begin
      if (up && !dn)      shadow_m[sel_m] = sat_up(shadow_m[sel_m]);
      else if (dn && !up) shadow_m[sel_m] = sat_dn(shadow_m[sel_m]);
      if (e == 0 && sel)  sel_m = (sel_m + 1) % N_CH;
    end
  endtask

  // Let at least one full period commit the shadows, then check everything.
  task automatic check_all(input string tag);
    int cnt [N_CH];
    tick(2 * PER + 8);
    chk({tag, "_sel"}, 32'(sel_ch), sel_m);
    chk({tag, "_duty_sel"}, 32'(duty_sel), shadow_m[sel_m]);
    for (int c = 0; c < N_CH; c++) cnt[c] = 0;
    for (int i = 0; i < PER; i++) begin
      for (int c = 0; c < N_CH; c++) if (led[c]) cnt[c]++;
      @(negedge clk);
    end
    for (int c = 0; c < N_CH; c++)
      chk($sformatf("%s_led%0d_highs", tag, c), cnt[c], led_highs(shadow_m[c]));
  endtask

`ifdef LED_PWM_BREATHE_EN
  task automatic tri_step(inout int v, inout bit up);
    if (up) begin
      if (v == MAXV) begin up = 1'b0; v = v - 1; end
      else v = v + 1;
    end else begin
      if (v == 0) begin up = 1'b1; v = v + 1; end
      else v = v - 1;
    end
  endtask
`endif

  initial begin
    int  cnt;
    bit  prev, found;
    int  m, k, hold;
    bit  mu, md, ms;
`ifdef LED_PWM_BREATHE_EN
    int  v;
    bit  dir;
`endif
    model_reset();

    // Reset held for 3 clks with keys bouncing.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk("rst_led", 32'(led), 0);
    chk("rst_sel", 32'(sel_ch), 0);
    chk("rst_duty_sel", 32'(duty_sel), 0);
    tick(2);
    chk("post_rst_duty_sel", 32'(duty_sel), 0);
    chk("post_rst_led", 32'(led), 0);

    // Debounce: toggling every 2 clks is rejected, a 6-clk hold is one event.
    for (int i = 0; i < 5; i++) begin
      key_up = 1'b1; tick(2);
      key_up = 1'b0; tick(2);
    end
    press(1'b1, 1'b0, 1'b0, 6, 0);
    check_all("debounce");

    // Saturation with auto-repeat in both directions.
    press(1'b1, 1'b0, 1'b0, 820, $urandom_range(0, 3));
    check_all("sat_up");
    press(1'b0, 1'b1, 1'b0, 820, $urandom_range(0, 3));
    check_all("to_zero");
    press(1'b0, 1'b1, 1'b0, 60, $urandom_range(0, 3));
    check_all("sat_dn");

    // Glitch-free commit: duty 8, press up early in a period.
    press(1'b1, 1'b0, 1'b0, 300, $urandom_range(0, 3));
    check_all("duty8");
    prev  = led[0];
    found = 1'b0;
    for (int i = 0; i < 3 * PER && !found; i++) begin
      @(negedge clk);
      if (led[0] && !prev) found = 1'b1;
      else prev = led[0];
    end
    chk("period_align", 32'(found), 1);
    cnt = 0;
    for (int i = 0; i < PER; i++) begin
      if (led[0]) cnt++;
      if (i == 0) key_up = 1'b1;
      if (i == 6) key_up = 1'b0;
      @(negedge clk);
    end
    chk("glitch_cur_period", cnt, 8);
    cnt = 0;
    for (int i = 0; i < PER; i++) begin
      if (led[0]) cnt++;
      @(negedge clk);
    end
    chk("glitch_next_period", cnt, 9);
    shadow_m[0] = sat_up(shadow_m[0]);
    tick(DEB + 8);

    // Channel select and wrap.
    press(1'b0, 1'b0, 1'b1, $urandom_range(4, 30), $urandom_range(0, 3));
    press(1'b1, 1'b0, 1'b0, $urandom_range(4, 30), $urandom_range(0, 3));
    press(1'b1, 1'b0, 1'b0, $urandom_range(4, 30), $urandom_range(0, 3));
    check_all("sel_ch1");
    press(1'b0, 1'b0, 1'b1, $urandom_range(4, 30), $urandom_range(0, 3));
    check_all("sel_wrap");

    // Simultaneous events.
    press(1'b1, 1'b1, 1'b0, 100, $urandom_range(0, 3));
    check_all("up_dn");
    press(1'b1, 1'b0, 1'b1, $urandom_range(4, 30), $urandom_range(0, 3));
    check_all("up_sel");

    // Random key combinations and hold lengths.
    for (int i = 0; i < 12; i++) begin
      m = $urandom_range(0, 5);
      mu = (m == 0) || (m == 3) || (m == 5);
      md = (m == 1) || (m == 4) || (m == 5);
      ms = (m == 2) || (m == 3) || (m == 4);
      k  = $urandom_range(0, 2);
      hold = (k == 0) ? $urandom_range(4, 30) : REP * k + 20;
      press(mu, md, ms, hold, $urandom_range(0, 3));
      check_all($sformatf("rand%0d", i));
    end

    // Reset in the middle of a period.
    tick($urandom_range(1, PER - 1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_led", 32'(led), 0);
    chk("midrst_sel", 32'(sel_ch), 0);
    chk("midrst_duty_sel", 32'(duty_sel), 0);
    model_reset();
    check_all("after_midrst");

`ifdef LED_PWM_BREATHE_EN
    // Triangle ramp on the selected channel, one step per period.
    breathe = 1'b1;
    tick(40);
    v = 32'(duty_sel);
    chk("breathe_start", 32'((v >= 1) && (v <= 3)), 1);
    dir = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(PER);
      tri_step(v, dir);
      chk($sformatf("breathe_step%0d", i), 32'(duty_sel), v);
    end
    // The shadow is one step ahead of the committed duty when frozen.
    breathe = 1'b0;
    tri_step(v, dir);
    tick(3 * PER);
    chk("breathe_freeze", 32'(duty_sel), v);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_dimmer.md
Name: led_pwm_dimmer

Overview:
Multi-channel, key-controlled LED PWM dimmer. Each channel has an independent duty register adjusted by debounced up/down keys with auto-repeat, and a select key that picks the channel being adjusted. Duty changes take effect only at PWM period boundaries, so outputs never glitch. The block sits between the board push-buttons and the LED pins.

Parameters:
N_CH, 4, number of LED channels (1..16)
PWM_W, 10, duty/PWM counter width; period = 2^PWM_W ticks
CLK_DIV, 16, clk cycles per PWM tick (>=1)
STEP, 1, duty increment/decrement per key event
DEB_CYCLES, 50000, clk cycles a key must be stable before its state is accepted
REPEAT_CYCLES, 2000000, clk cycles between auto-repeat events while a key is held

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_up  in  1  raw async button, high = pressed; raises duty of selected channel
key_dn  in  1  raw async button, high = pressed; lowers duty of selected channel
key_sel  in  1  raw async button, high = pressed; advances selected channel
led  out  N_CH  PWM outputs, high = LED on
sel_ch  out  max(1,clog2(N_CH))  currently selected channel index
duty_sel  out  PWM_W  committed (active) duty of the selected channel

Behaviour:
- Reset (rst=1 at posedge clk): all duty and shadow registers=0, prescaler=0, pwm_cnt=0, sel_ch=0, debouncers cleared to released, repeat timers=0; led=0, duty_sel=0 on the first cycle after reset. Reset mid-period aborts the period immediately.
- Key path, per key: 2-FF synchroniser -> debouncer. Stable state changes only after synchronised input differs from it for DEB_CYCLES consecutive clks; any bounce restarts the count.
- Press event: one-clk pulse on stable released->pressed edge. For key_up/key_dn only, while held, another pulse after REPEAT_CYCLES, then every REPEAT_CYCLES. key_sel has no auto-repeat.
- up and dn events in the same clk: no change. up/dn and sel in the same clk: the duty change applies to the old sel_ch, then sel_ch advances.
- sel event: sel_ch = sel_ch+1, wraps N_CH-1 -> 0. N_CH=1: sel_ch stays 0.
- Up event: shadow[sel] = min(shadow+STEP, 2^PWM_W-1). Down event: shadow[sel] = max(shadow-STEP, 0). Computed at PWM_W+1 bits; saturating, never wraps.
- Prescaler counts 0..CLK_DIV-1; tick when it equals CLK_DIV-1. pwm_cnt increments on tick, wraps 2^PWM_W-1 -> 0.
- Period boundary = tick with pwm_cnt wrapping to 0: all duty[i] <= shadow[i] in that same clk.
- led[i] registered: 1 when pwm_cnt < duty[i], or when duty[i] = 2^PWM_W-1 (fully on, no off tick). duty=0 -> always off. One clk latency from pwm_cnt to led.
- duty_sel = duty[sel_ch] (committed value, not shadow); follows sel_ch combinationally.

Optional Feature:
Macro LED_PWM_BREATHE_EN. Defined: adds input port breathe (1 bit, level). While breathe=1, the selected channel's shadow ramps by STEP once per PWM period: up to 2^PWM_W-1, then down to 0, repeating (triangle). Direction flag resets to "up". key_up/key_dn are ignored for that channel, and key_sel still works. On sel change or breathe=0 the ramp freezes at its current value. Undefined: port absent, no ramp logic; behaviour exactly as above.

Test Plan:
Bench parameters: N_CH=2, PWM_W=4, CLK_DIV=1, STEP=1, DEB_CYCLES=4, REPEAT_CYCLES=40.
- Reset: assert rst 3 clks with keys bouncing -> led=00, sel_ch=0, duty_sel=0. No event for 2 clks after release.
- Debounce: key_up toggles every 2 clks for 20 clks, then held 6 clks and released -> exactly one up event. duty_sel 0->1 at the next period boundary. led[0] high 1 of 16 clks per period.
- Saturation/repeat: hold key_up 800 clks -> duty_sel reaches 15 and stays. led[0] constantly 1. Hold key_dn from 0 -> stays 0, led[0]=0.
- Glitch-free commit: duty=8; press up mid-period at pwm_cnt=3 -> current period has 8 high clks, next period 9.
- Channel select: sel press -> sel_ch=1, two up presses -> duty[1]=2, duty[0] unchanged. Second sel press -> sel_ch wraps to 0.
- Simultaneous: up and dn debounced on the same clk -> duty unchanged. With LED_PWM_BREATHE_EN and breathe=1: duty_sel follows 0,1..15,14..0 one step per 16-clk period.
